eco32f_lsu: RTL

ECO32F_LSU -- requirements
Module: eco32f_lsu

---
 rtl/eco32f_pkg.sv | 26 ++
 rtl/eco32f_lsu_align.sv | 57 +++++
 rtl/eco32f_lsu.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/eco32f_pkg.sv
// Shared definitions for the ECO32F load/store unit: access size codes,
// LSU state encoding and the alignment rule.
package eco32f_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    LSU_IDLE   = 1'b0,
    LSU_ACCESS = 1'b1
  } lsu_state_e;

  // Size code 2'b11 is illegal and behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic m;
    m = 1'b0;
    case (size)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = off[0];
      default: m = |off;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/eco32f_lsu_align.sv
// Big-endian lane steering: store byte-select/replication and load
// extraction with zero/sign extension. Purely combinational.
module eco32f_lsu_align
  import eco32f_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_signed,
  input  logic [31:0] ld_data,
  output logic [3:0]  st_sel,
  output logic [31:0] st_dat,
  output logic [31:0] ld_result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    st_sel = 4'b1111;
    st_dat = st_data;
    case (st_size)
      SZ_BYTE: begin
        st_sel = 4'b1000 >> st_off;
        st_dat = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        st_sel = st_off[1] ? 4'b0011 : 4'b1100;
        st_dat = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Offset 0 is the most significant lane.
  always_comb begin
    byte_v = ld_data[31:24];
    case (ld_off)
      2'd0: byte_v = ld_data[31:24];
      2'd1: byte_v = ld_data[23:16];
      2'd2: byte_v = ld_data[15:8];
      2'd3: byte_v = ld_data[7:0];
      default: ;
    endcase
    half_v = ld_off[1] ? ld_data[15:0] : ld_data[31:16];

    ld_result = ld_data;
    case (ld_size)
      SZ_BYTE: ld_result = {{24{ld_signed & byte_v[7]}}, byte_v};
      SZ_HALF: ld_result = {{16{ld_signed & half_v[15]}}, half_v};
      default: ;
    endcase
  end

endmodule

// File: rtl/eco32f_lsu.sv
// ECO32F load/store unit: one outstanding data-bus access, alignment and
// bus-error exceptions, registered load writeback.
//
// state      | meaning
// LSU_IDLE   | no bus cycle; accepts a new load/store
// LSU_ACCESS | cyc/stb asserted, waiting for ack or err
module eco32f_lsu
  import eco32f_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_stall,
  input  logic        ex_op_load,
  input  logic        ex_op_store,
  input  logic [1:0]  ex_ls_size,
  input  logic        ex_ls_signed,
  input  logic [31:0] ex_add_result,
  input  logic [31:0] ex_rf_y,
  output logic [31:0] dbus_adr_o,
  output logic [31:0] dbus_dat_o,
  output logic [3:0]  dbus_sel_o,
  output logic        dbus_we_o,
  output logic        dbus_cyc_o,
  output logic        dbus_stb_o,
  input  logic [31:0] dbus_dat_i,
  input  logic        dbus_ack_i,
  input  logic        dbus_err_i,
  output logic        lsu_stall,
  output logic        mem_except_align,
  output logic        mem_except_bus,
  output logic [31:0] mem_badaddr,
  output logic        wb_op_load,
  output logic [31:0] wb_lsu_result
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        align_exc_q, align_exc_d;
  logic        bus_exc_q, bus_exc_d;
  logic [31:0] badaddr_q, badaddr_d;
  logic        wb_load_q, wb_load_d;
  logic [31:0] wb_result_q, wb_result_d;

  logic        accept;
  logic        misaligned;
  logic        take;
  logic [3:0]  st_sel;
  logic [31:0] st_dat;
  logic [31:0] ld_result;

  eco32f_lsu_align u_align (
    .st_size   (ex_ls_size),
    .st_off    (ex_add_result[1:0]),
    .st_data   (ex_rf_y),
    .ld_size   (size_q),
    .ld_off    (addr_q[1:0]),
    .ld_signed (signed_q),
    .ld_data   (dbus_dat_i),
    .st_sel    (st_sel),
    .st_dat    (st_dat),
    .ld_result (ld_result)
  );

  assign accept     = (ex_op_load | ex_op_store) & ~ex_stall;
  assign misaligned = is_misaligned(ex_ls_size, ex_add_result[1:0]);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    size_d      = size_q;
    signed_d    = signed_q;
    align_exc_d = 1'b0;
    bus_exc_d   = 1'b0;
    badaddr_d   = badaddr_q;
    wb_load_d   = 1'b0;
    wb_result_d = wb_result_q;
    take        = 1'b0;

    case (state_q)
      LSU_IDLE: take = accept;
      LSU_ACCESS: begin
        // err has priority over a simultaneous ack; an erroring access never chains.
        if (dbus_err_i) begin
          bus_exc_d = 1'b1;
          badaddr_d = addr_q;
          state_d   = LSU_IDLE;
        end else if (dbus_ack_i) begin
          wb_load_d = ~we_q;
          if (!we_q) wb_result_d = ld_result;
          state_d = LSU_IDLE;
          take    = accept;
        end
      end
      default: state_d = LSU_IDLE;
    endcase

    if (take) begin
      if (misaligned) begin
        align_exc_d = 1'b1;
        badaddr_d   = ex_add_result;
      end else begin
        state_d  = LSU_ACCESS;
        addr_d   = ex_add_result;
        dat_d    = st_dat;
        sel_d    = st_sel;
        we_d     = ex_op_store;
        size_d   = ex_ls_size;
        signed_d = ex_ls_signed;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LSU_IDLE;
      addr_q      <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= SZ_WORD;
      signed_q    <= 1'b0;
      align_exc_q <= 1'b0;
      bus_exc_q   <= 1'b0;
      badaddr_q   <= '0;
      wb_load_q   <= 1'b0;
      wb_result_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      align_exc_q <= align_exc_d;
      bus_exc_q   <= bus_exc_d;
      badaddr_q   <= badaddr_d;
      wb_load_q   <= wb_load_d;
      wb_result_q <= wb_result_d;
    end
  end

  assign dbus_cyc_o       = (state_q == LSU_ACCESS);
  assign dbus_stb_o       = dbus_cyc_o;
  assign dbus_we_o        = dbus_cyc_o & we_q;
  assign dbus_sel_o       = dbus_cyc_o ? sel_q : 4'b0000;
  assign dbus_adr_o       = {addr_q[31:2], 2'b00};
  assign dbus_dat_o       = dat_q;
  assign lsu_stall        = dbus_cyc_o & ~(dbus_ack_i | dbus_err_i);
  assign mem_except_align = align_exc_q;
  assign mem_except_bus   = bus_exc_q;
  assign mem_badaddr      = badaddr_q;
  assign wb_op_load       = wb_load_q;
  assign wb_lsu_result    = wb_result_q;

endmodule
